sync_fifo: RTL and testbench

Parametrised single-clock first-in/first-out buffer built on an inferred word memory, generalising the fixed 8-bit storage array into a configurable width/depth queue. It adds push/pop handshakes, status flags, an occupancy count, a programmable almost-full threshold, a synchronous flush and sticky error flags. It sits between producer and consumer blocks in the same clock domain, for example as a command queue or a stream elastic buffer.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_mem.sv | 23 ++
 rtl/sync_fifo.sv | 89 ++++++++
 tb/tb_sync_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo: address-width calculation and parameter legality.
package sync_fifo_pkg;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

   function automatic bit params_legal(input int width, input int depth, input int af_level);
      return (width >= 1) && is_pow2(depth) && (af_level >= 1) && (af_level <= depth);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// fifo_mem: WIDTH x DEPTH word array, registered write port, unregistered read port.
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             CLK,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers with wrap bit, status flags, sticky ovf/udf,
// synchronous flush and a registered read-data port.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   localparam int AW      = clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic [AW:0]      count,
   output logic             ovf,
   output logic             udf
);

   if (!params_legal(WIDTH, DEPTH, AF_LEVEL)) begin : g_bad_params
      $error("sync_fifo: DEPTH must be a power of two >= 2 and 1 <= AF_LEVEL <= DEPTH");
   end

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] AF_THR  = AF_LEVEL[AW:0];

   logic [AW:0]      wp;
   logic [AW:0]      rp;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] mem_rdata;

   // Flags derive only from registered pointers, so they move after an edge or RST.
   assign count       = wp - rp;
   assign empty       = (wp == rp);
   assign full        = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
   assign almost_full = (count >= AF_THR);

   assign push = wr_en & ~full;
   assign pop  = rd_en & ~empty;

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .CLK   (CLK),
      .we    (push & ~clr),
      .waddr (wp[AW-1:0]),
      .wdata (wr_data),
      .raddr (rp[AW-1:0]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wp       <= '0;
         rp       <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else if (clr) begin
         // Flush wins over any push/pop in the same cycle; rd_data keeps its value.
         wp       <= '0;
         rp       <= '0;
         rd_valid <= 1'b0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else begin
         if (push) wp <= wp + PTR_ONE;
         if (pop) begin
            rd_data <= mem_rdata;
            rp      <= rp + PTR_ONE;
         end
         rd_valid <= pop;
         if (wr_en && full)  ovf <= 1'b1;
         if (rd_en && empty) udf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (WIDTH=8, DEPTH=4, AF_LEVEL=3).
module tb_sync_fifo;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic [2:0] count;
   logic       ovf;
   logic       udf;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_word;

   sync_fifo #(
      .WIDTH    (8),
      .DEPTH    (4),
      .AF_LEVEL (3)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .clr         (clr),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .ovf         (ovf),
      .udf         (udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [7:0] wd, input logic re);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      step();
      step();
      chk("reset_count", 32'(count), 0);
      chk("reset_empty", 32'(empty), 1);
      chk("reset_full", 32'(full), 0);
      chk("reset_af", 32'(almost_full), 0);
      chk("reset_rd_valid", 32'(rd_valid), 0);
      chk("reset_rd_data", 32'(rd_data), 0);
      chk("reset_ovf", 32'(ovf), 0);
      chk("reset_udf", 32'(udf), 0);
      rst = 1'b0;

      // Fill
      drive(1'b1, 8'h11, 1'b0); step();
      chk("fill1_count", 32'(count), 1);
      chk("fill1_empty", 32'(empty), 0);
      chk("fill1_af", 32'(almost_full), 0);
      drive(1'b1, 8'h22, 1'b0); step();
      chk("fill2_af", 32'(almost_full), 0);
      drive(1'b1, 8'h33, 1'b0); step();
      chk("fill3_count", 32'(count), 3);
      chk("fill3_af", 32'(almost_full), 1);
      chk("fill3_full", 32'(full), 0);
      drive(1'b1, 8'h44, 1'b0); step();
      chk("fill4_count", 32'(count), 4);
      chk("fill4_full", 32'(full), 1);
      chk("fill4_ovf", 32'(ovf), 0);
      drive(1'b1, 8'h55, 1'b0); step();
      chk("fill5_count", 32'(count), 4);
      chk("fill5_ovf", 32'(ovf), 1);

      // Drain order
      drive(1'b0, 8'h00, 1'b1); step();
      chk("drain1_data", 32'(rd_data), 32'h11);
      chk("drain1_valid", 32'(rd_valid), 1);
      chk("drain1_count", 32'(count), 3);
      step();
      chk("drain2_data", 32'(rd_data), 32'h22);
      chk("drain2_valid", 32'(rd_valid), 1);
      step();
      chk("drain3_data", 32'(rd_data), 32'h33);
      step();
      chk("drain4_data", 32'(rd_data), 32'h44);
      chk("drain4_valid", 32'(rd_valid), 1);
      chk("drain4_empty", 32'(empty), 1);
      chk("drain4_udf", 32'(udf), 0);
      step();
      chk("drain5_valid", 32'(rd_valid), 0);
      chk("drain5_udf", 32'(udf), 1);
      chk("drain5_data_hold", 32'(rd_data), 32'h44);
      chk("drain5_count", 32'(count), 0);
      drive(1'b0, 8'h00, 1'b0); step();
      chk("idle_valid", 32'(rd_valid), 0);

      // Reset mid-stream with 2 words held and rd_valid high
      drive(1'b1, 8'hAA, 1'b0); step();
      drive(1'b1, 8'hBB, 1'b0); step();
      drive(1'b1, 8'hCC, 1'b0); step();
      drive(1'b0, 8'h00, 1'b1); step();
      chk("pre_rst_valid", 32'(rd_valid), 1);
      chk("pre_rst_data", 32'(rd_data), 32'hAA);
      chk("pre_rst_count", 32'(count), 2);
      drive(1'b0, 8'h00, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_empty", 32'(empty), 1);
      chk("async_rst_valid", 32'(rd_valid), 0);
      chk("async_rst_ovf", 32'(ovf), 0);
      chk("async_rst_udf", 32'(udf), 0);
      chk("async_rst_data", 32'(rd_data), 0);
      step();
      rst = 1'b0;

      // Simultaneous push/pop at count=2, scoreboard-tracked
      exp_q.delete();
      drive(1'b1, 8'h01, 1'b0); step(); exp_q.push_back(8'h01);
      drive(1'b1, 8'h02, 1'b0); step(); exp_q.push_back(8'h02);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'(i + 3), 1'b1);
         step();
         exp_q.push_back(8'(i + 3));
         exp_word = exp_q.pop_front();
         chk($sformatf("stream%0d_data", i), 32'(rd_data), 32'(exp_word));
         chk($sformatf("stream%0d_valid", i), 32'(rd_valid), 1);
         chk($sformatf("stream%0d_count", i), 32'(count), 2);
      end

      // Push+pop at full: only the pop happens
      drive(1'b1, 8'h0D, 1'b0); step(); exp_q.push_back(8'h0D);
      drive(1'b1, 8'h0E, 1'b0); step(); exp_q.push_back(8'h0E);
      chk("full_pre_full", 32'(full), 1);
      chk("full_pre_ovf", 32'(ovf), 0);
      drive(1'b1, 8'hEE, 1'b1); step();
      exp_word = exp_q.pop_front();
      chk("full_pp_count", 32'(count), 3);
      chk("full_pp_data", 32'(rd_data), 32'(exp_word));
      chk("full_pp_valid", 32'(rd_valid), 1);
      chk("full_pp_ovf", 32'(ovf), 1);
      chk("full_pp_full", 32'(full), 0);
      drive(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         exp_word = exp_q.pop_front();
         chk($sformatf("full_drain%0d_data", i), 32'(rd_data), 32'(exp_word));
      end
      chk("full_drain_empty", 32'(empty), 1);
      chk("full_drain_udf", 32'(udf), 0);

      // Push+pop at empty: only the push happens, no fall-through
      drive(1'b1, 8'h5A, 1'b1); step();
      chk("empty_pp_count", 32'(count), 1);
      chk("empty_pp_valid", 32'(rd_valid), 0);
      chk("empty_pp_udf", 32'(udf), 1);
      chk("empty_pp_empty", 32'(empty), 0);
      drive(1'b0, 8'h00, 1'b1); step();
      chk("empty_pop_data", 32'(rd_data), 32'h5A);
      chk("empty_pop_valid", 32'(rd_valid), 1);
      chk("empty_pop_count", 32'(count), 0);

      // Flush with concurrent push
      drive(1'b1, 8'h61, 1'b0); step();
      drive(1'b1, 8'h62, 1'b0); step();
      drive(1'b1, 8'h63, 1'b0); step();
      chk("flush_pre_count", 32'(count), 3);
      chk("flush_pre_ovf", 32'(ovf), 1);
      clr = 1'b1;
      drive(1'b1, 8'h77, 1'b0); step();
      clr = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      chk("flush_count", 32'(count), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_ovf", 32'(ovf), 0);
      chk("flush_udf", 32'(udf), 0);
      chk("flush_valid", 32'(rd_valid), 0);
      chk("flush_data_hold", 32'(rd_data), 32'h5A);
      drive(1'b1, 8'h88, 1'b0); step();
      drive(1'b0, 8'h00, 1'b1); step();
      chk("post_flush_data", 32'(rd_data), 32'h88);
      chk("post_flush_valid", 32'(rd_valid), 1);
      chk("post_flush_count", 32'(count), 0);
      drive(1'b0, 8'h00, 1'b0); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
